// File: rtl/alu_datapath_if.sv
// Operand, control and result bundle of the ALU datapath.
// With ALU_DATAPATH_OVERFLOW_EN defined the bundle also carries the overflow flag.
interface alu_datapath_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] a;
    logic [DATA_BITS-1:0] imm;
    logic [DATA_BITS-1:0] b_reg;
    logic                 b_sel;
    logic                 cin;
    logic [DATA_BITS-1:0] load_data;
    logic [1:0]           wb_sel;
    logic [DATA_BITS-1:0] result;
    logic                 cout;
    logic                 zero;
    logic [DATA_BITS-1:0] wb_data;
`ifdef ALU_DATAPATH_OVERFLOW_EN
    logic                 overflow;

    modport master (
        output a, imm, b_reg, b_sel, cin, load_data, wb_sel,
        input  result, cout, zero, wb_data, overflow
    );
    modport slave (
        input  a, imm, b_reg, b_sel, cin, load_data, wb_sel,
        output result, cout, zero, wb_data, overflow
    );
`else
    modport master (
        output a, imm, b_reg, b_sel, cin, load_data, wb_sel,
        input  result, cout, zero, wb_data
    );
    modport slave (
        input  a, imm, b_reg, b_sel, cin, load_data, wb_sel,
        output result, cout, zero, wb_data
    );
`endif
endinterface

// File: rtl/alu_datapath.sv
// Add/subtract ALU with registered result/carry/zero and a combinational write-back mux.
// Optional registered signed-overflow flag enabled by macro ALU_DATAPATH_OVERFLOW_EN.
module mux2to1 #(
    parameter int DATA_BITS = 8
) (
    input  logic                 sel,
    input  logic [DATA_BITS-1:0] in0,
    input  logic [DATA_BITS-1:0] in1,
    output logic [DATA_BITS-1:0] out
);
    assign out = sel ? in1 : in0;
endmodule

module mux4to1 #(
    parameter int DATA_BITS = 8
) (
    input  logic [1:0]           sel,
    input  logic [DATA_BITS-1:0] in0,
    input  logic [DATA_BITS-1:0] in1,
    input  logic [DATA_BITS-1:0] in2,
    input  logic [DATA_BITS-1:0] in3,
    output logic [DATA_BITS-1:0] out
);
    always_comb begin
        out = in0;
        case (sel)
            2'd0: out = in0;
            2'd1: out = in1;
            2'd2: out = in2;
            2'd3: out = in3;
            default: out = in0;
        endcase
    end
endmodule

module alu_datapath #(
    parameter int DATA_BITS = 8
) (
    input  logic         clk,
    input  logic         reset,
    alu_datapath_if.slave bus
);
    logic [DATA_BITS-1:0] b;
    logic [DATA_BITS-1:0] b_eff;
    logic [DATA_BITS:0]   sum_next;
    logic [DATA_BITS-1:0] result_reg;
    logic                 cout_reg;
    logic                 zero_reg;

    mux2to1 #(.DATA_BITS(DATA_BITS)) u_b_mux (
        .sel (bus.b_sel),
        .in0 (bus.imm),
        .in1 (bus.b_reg),
        .out (b)
    );

    // Subtract is a + ~b + 1, so cin doubles as the two's-complement increment.
    assign b_eff    = bus.cin ? ~b : b;
    assign sum_next = {1'b0, bus.a} + {1'b0, b_eff} + {{DATA_BITS{1'b0}}, bus.cin};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_reg <= '0;
            cout_reg   <= 1'b0;
            zero_reg   <= 1'b0;
        end else begin
            result_reg <= sum_next[DATA_BITS-1:0];
            cout_reg   <= sum_next[DATA_BITS];
            zero_reg   <= (sum_next[DATA_BITS-1:0] == '0);
        end
    end

`ifdef ALU_DATAPATH_OVERFLOW_EN
    logic overflow_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= (bus.a[DATA_BITS-1] == b_eff[DATA_BITS-1]) &&
                            (sum_next[DATA_BITS-1] != bus.a[DATA_BITS-1]);
        end
    end

    assign bus.overflow = overflow_reg;
`endif

    assign bus.result = result_reg;
    assign bus.cout   = cout_reg;
    assign bus.zero   = zero_reg;

    mux4to1 #(.DATA_BITS(DATA_BITS)) u_wb_mux (
        .sel (bus.wb_sel),
        .in0 (result_reg),
        .in1 (bus.imm),
        .in2 (bus.load_data),
        .in3 (bus.a),
        .out (bus.wb_data)
    );
endmodule

// File: tb/tb_alu_datapath.sv
// Randomized scoreboard bench for alu_datapath: stimulus pushes expected results,
// a monitor pops and compares one cycle later.
module tb_alu_datapath;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] result;
        logic          cout;
        logic          zero;
        logic [DW-1:0] wb;
        logic          ovf;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    alu_datapath_if #(.DATA_BITS(DW)) bus ();

    alu_datapath #(.DATA_BITS(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= 2 ** (DW - 1)) ? v - 2 ** DW : v;
    endfunction

    // Reference: plain integer add/subtract, not a gate-level restatement.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] imm,
                                   input logic [DW-1:0] b_reg, input logic b_sel,
                                   input logic cin, input logic [DW-1:0] ld,
                                   input logic [1:0] wb_sel);
        exp_t e;
        int av, bv, s, ss;
        av = int'(a);
        bv = b_sel ? int'(b_reg) : int'(imm);
        if (!cin) begin
            s      = av + bv;
            e.cout = (s >= 2 ** DW);
            ss     = to_signed(av) + to_signed(bv);
        end else begin
            s      = av - bv;
            e.cout = (av >= bv);
            ss     = to_signed(av) - to_signed(bv);
        end
        s        = (s + 2 ** DW) % (2 ** DW);
        e.result = DW'(s);
        e.zero   = (s == 0);
        e.ovf    = (ss > 2 ** (DW - 1) - 1) || (ss < -(2 ** (DW - 1)));
        case (wb_sel)
            2'd0:    e.wb = e.result;
            2'd1:    e.wb = imm;
            2'd2:    e.wb = ld;
            default: e.wb = a;
        endcase
        return e;
    endfunction

    task automatic set_inputs(input logic [DW-1:0] a, input logic [DW-1:0] imm,
                              input logic [DW-1:0] b_reg, input logic b_sel,
                              input logic cin, input logic [DW-1:0] ld,
                              input logic [1:0] wb_sel);
        bus.a = a; bus.imm = imm; bus.b_reg = b_reg; bus.b_sel = b_sel;
        bus.cin = cin; bus.load_data = ld; bus.wb_sel = wb_sel;
    endtask

    task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] imm,
                         input logic [DW-1:0] b_reg, input logic b_sel,
                         input logic cin, input logic [DW-1:0] ld,
                         input logic [1:0] wb_sel);
        exp_t e;
        @(negedge clk);
        set_inputs(a, imm, b_reg, b_sel, cin, ld, wb_sel);
        e = model(a, imm, b_reg, b_sel, cin, ld, wb_sel);
        exp_q.push_back(e);
        $display("txn a=%02h imm=%02h b_reg=%02h b_sel=%0b cin=%0b ld=%02h wb_sel=%0d -> exp result=%02h cout=%0b zero=%0b",
                 a, imm, b_reg, b_sel, cin, ld, wb_sel, e.result, e.cout, e.zero);
        if (wb_sel != 2'd0) begin
            #1;
            check("wb_data_same_cycle", 32'(bus.wb_data), 32'(e.wb));
        end
    endtask

    // Monitor: outputs are valid every cycle, so one expected entry per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("result",  32'(bus.result),  32'(e.result));
                check("cout",    32'(bus.cout),    32'(e.cout));
                check("zero",    32'(bus.zero),    32'(e.zero));
                check("wb_data", 32'(bus.wb_data), 32'(e.wb));
`ifdef ALU_DATAPATH_OVERFLOW_EN
                check("overflow", 32'(bus.overflow), 32'(e.ovf));
`endif
            end
        end
    end

    initial begin
        exp_t e;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        set_inputs(8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 8'h00, 2'd0);
        #12;
        check("rst_result",  32'(bus.result),  32'h0);
        check("rst_cout",    32'(bus.cout),    32'h0);
        check("rst_zero",    32'(bus.zero),    32'h0);
        check("rst_wb_data", 32'(bus.wb_data), 32'h0);
`ifdef ALU_DATAPATH_OVERFLOW_EN
        check("rst_overflow", 32'(bus.overflow), 32'h0);
`endif
        @(negedge clk);
        reset = 1'b1;

        drive(8'h05, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0);
        drive(8'hFF, 8'h00, 8'h01, 1'b1, 1'b0, 8'h00, 2'd0);
        drive(8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 8'h00, 2'd0);
        drive(8'h03, 8'h05, 8'h00, 1'b0, 1'b1, 8'h00, 2'd0);
        drive(8'h10, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00, 2'd1);
        drive(8'h10, 8'h01, 8'h00, 1'b0, 1'b0, 8'h3C, 2'd2);
        drive(8'h77, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 2'd3);
        drive(8'h7F, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0);
        drive(8'h80, 8'h01, 8'h00, 1'b0, 1'b1, 8'h00, 2'd0);

        for (int i = 0; i < 300; i++) begin
            drive(DW'($urandom), DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
                  DW'($urandom), 2'($urandom));
        end

        // Asynchronous reset mid-operation, away from any clock edge.
        @(posedge clk);
        #3;
        reset = 1'b0;
        bus.wb_sel = 2'd0;
        #1;
        check("midrst_result",  32'(bus.result),  32'h0);
        check("midrst_cout",    32'(bus.cout),    32'h0);
        check("midrst_zero",    32'(bus.zero),    32'h0);
        check("midrst_wb_data", 32'(bus.wb_data), 32'h0);
        set_inputs(8'h20, 8'h22, 8'h09, 1'b1, 1'b1, 8'h00, 2'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        e = model(8'h20, 8'h22, 8'h09, 1'b1, 1'b1, 8'h00, 2'd0);
        exp_q.push_back(e);
        $display("txn post-reset a=20 b_reg=09 sub -> exp result=%02h", e.result);

        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0);
        for (int i = 0; i < 50; i++) begin
            drive(DW'($urandom), DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
                  DW'($urandom), 2'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_datapath.md
ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, giving the operand/result width in bits.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port a, input, DATA_BITS: ALU operand A; also write-back mux input 3.
REQ-005 SHALL have port imm, input, DATA_BITS: immediate value; B-mux input 0 and write-back mux input 1.
REQ-006 SHALL have port b_reg, input, DATA_BITS: register-file operand; B-mux input 1.
REQ-007 SHALL have port b_sel, input, 1: B-operand select (0=imm, 1=b_reg).
REQ-008 SHALL have port cin, input, 1: subtract request and carry-in (1=subtract).
REQ-009 SHALL have port load_data, input, DATA_BITS: memory load value; write-back mux input 2.
REQ-010 SHALL have port wb_sel, input, 2: write-back select (0=result, 1=imm, 2=load_data, 3=a).
REQ-011 SHALL have port result, output, DATA_BITS: registered ALU sum/difference.
REQ-012 SHALL have port cout, output, 1: registered carry out (on subtract, 1 = no borrow).
REQ-013 SHALL have port zero, output, 1: registered flag, 1 when the registered result is zero.
REQ-014 SHALL have port wb_data, output, DATA_BITS: combinational write-back mux output.

Function
REQ-015 SHALL contain submodules mux2to1 and mux4to1, each purely combinational with a DATA_BITS parameter (default 8) and ports sel, in0..inN, out.
REQ-016 SHALL form operand B through mux2to1: b = b_sel ? b_reg : imm, with zero latency.
REQ-017 SHALL, on each rising clk edge while reset is high, compute {cout, result} <= a + (cin ? ~b : b) + cin at DATA_BITS+1 bits.
REQ-018 SHALL discard the carry beyond DATA_BITS from result, so the result wraps modulo 2^DATA_BITS.
REQ-019 SHALL load zero <= (new result == 0) on the same edge as result, so zero always matches the registered result.
REQ-020 SHALL give the ALU a latency of exactly one clock: inputs sampled at edge N appear on result/cout/zero after edge N.
REQ-021 SHALL update the ALU every cycle; there is no enable and no hold state.
REQ-022 SHALL drive wb_data through mux4to1 selected by wb_sel, with no added latency; selection 0 drives the registered result.
REQ-023 SHALL propagate any change on wb_sel, imm, load_data or a to wb_data within the same cycle.
REQ-024 SHALL leave out all other operations (logic, shift, compare); only add and subtract are supported.

Reset
REQ-025 SHALL, while reset is low and independent of clk, force result=0, cout=0 and zero=0.
REQ-026 SHALL keep wb_data combinational during reset; with wb_sel=0 it reads 0.
REQ-027 SHALL, when reset is asserted mid-operation, discard the pending computation; the first edge after release computes from the inputs then present.

Configuration
REQ-028 SHALL, with macro ALU_DATAPATH_OVERFLOW_EN defined, add output overflow (1 bit, registered, reset 0) set when a and the effective B operand share a sign bit and result's sign bit differs.
REQ-029 SHALL, without ALU_DATAPATH_OVERFLOW_EN, have no overflow port and no overflow logic; all other behaviour is identical.

Verification
REQ-030 SHALL cover reset: reset=0 -> result=0x00, cout=0, zero=0; wb_sel=0 -> wb_data=0x00.
REQ-031 SHALL cover add immediate: a=0x05, imm=0x03, b_sel=0, cin=0, one edge -> result=0x08, cout=0, zero=0.
REQ-032 SHALL cover add register with wrap: a=0xFF, b_reg=0x01, b_sel=1, cin=0 -> result=0x00, cout=1, zero=1.
REQ-033 SHALL cover subtract: a=0x05, imm=0x05, cin=1 -> result=0x00, cout=1, zero=1; then a=0x03 -> result=0xFE, cout=0, zero=0.
REQ-034 SHALL cover the write-back mux: wb_sel=1, imm=0xA5 -> wb_data=0xA5 same cycle; wb_sel=2, load_data=0x3C -> 0x3C; wb_sel=3, a=0x77 -> 0x77.
REQ-035 SHALL cover overflow, with ALU_DATAPATH_OVERFLOW_EN defined: a=0x7F, imm=0x01, cin=0 -> result=0x80, overflow=1, cout=0.
